fpu_mds_arbiter: RTL

FPU_MDS_ARBITER -- requirements
Module: fpu_mds_arbiter

---
 rtl/fpu_mds_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fpu_mds_arbiter.sv
// fpu_mds_arbiter: round-robin arbiter between two requesters sharing one
// mul/div/sqrt unit. Issues a start pulse, waits for completion (guarded by a
// watchdog), and holds the response until the consumer takes it.
module fpu_mds_arbiter #(
    parameter int TAG_W    = 4,
    parameter int WDOG_MAX = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [5:0]           req_rm,
    input  logic [63:0]          req_a,
    input  logic [63:0]          req_b,
    input  logic [2*TAG_W-1:0]   req_tag,
    input  logic                 flush,
    output logic                 mds_start,
    output logic [1:0]           mds_op,
    output logic [2:0]           mds_rm,
    output logic [31:0]          mds_a,
    output logic [31:0]          mds_b,
    input  logic                 mds_done,
    input  logic [31:0]          mds_result,
    input  logic [4:0]           mds_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [31:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic                 busy,
    output logic                 wdog_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(WDOG_MAX - 1);

    state_t     state;
    logic       last_grant;
    logic [7:0] wd_cnt;
    logic [1:0] grant;
    logic       grant_id;

    // Round-robin pick: on contention the requester that did not win last time
    always_comb begin
        grant = '0;
        if (req_valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
        else
            grant = req_valid;
    end

    assign grant_id = grant[1];

    // Acceptance is only offered in IDLE when not flushing and out of reset
    always_comb begin
        req_ready = '0;
        if (reset && (state == IDLE) && !flush)
            req_ready = grant;
    end

    // A flush arriving during ISSUE cancels the start pulse in the same cycle
    assign mds_start = (state == ISSUE) && !flush;
    assign busy      = (state != IDLE);

    // Main control FSM with registered operand and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            mds_op     <= '0;
            mds_rm     <= '0;
            mds_a      <= '0;
            mds_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            wdog_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && (req_valid != 2'b00)) begin
                        mds_op     <= grant_id ? req_op[3:2]   : req_op[1:0];
                        mds_rm     <= grant_id ? req_rm[5:3]   : req_rm[2:0];
                        mds_a      <= grant_id ? req_a[63:32]  : req_a[31:0];
                        mds_b      <= grant_id ? req_b[63:32]  : req_b[31:0];
                        rsp_tag    <= grant_id ? req_tag[2*TAG_W-1:TAG_W]
                                               : req_tag[TAG_W-1:0];
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Unit was never started, so there is nothing to drain
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mds_done) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            rsp_result <= mds_result;
                            rsp_flags  <= mds_flags;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        wdog_err <= 1'b1;
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            rsp_result <= 32'h7fc0_0000;
                            rsp_flags  <= 5'b10000;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                        if (flush)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Watchdog keeps counting from where WAIT left off
                    if (mds_done) begin
                        state <= IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        wdog_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
